// File: rtl/bin_to_ascii_dec.sv
// Sequential binary to decimal-ASCII formatter (shift-add-3) for the LCD row path.
// Ports: clk/rst_n; in_valid/in_ready/in_data/blank_lz in; out_valid/out_ready/out_chars/out_ovf out.
module bin_to_ascii_dec #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  blank_lz,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*DIGITS-1:0]   out_chars,
  output logic                  out_ovf
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IN_W-1:0]     shift_q, shift_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                blank_q, blank_d;
  logic                ovf_q, ovf_d;
  logic [8*DIGITS-1:0] chars_q, chars_d;
  logic                oovf_q, oovf_d;

  logic [BW-1:0]       bcd_adj;
  logic [BW-1:0]       bcd_shl;
  logic [IN_W-1:0]     shift_shl;
  logic [8*DIGITS-1:0] fmt;
  logic [3:0]          nib;
  logic                lead;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_chars = chars_q;
  assign out_ovf   = oovf_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Top BCD bit falls off; over-range values are covered by ovf_q.
  assign bcd_shl   = {bcd_adj[BW-2:0], shift_q[IN_W-1]};
  assign shift_shl = shift_q << 1;

  // Walk from the most significant digit; lead stays set while only
  // zeros have been seen, and digit 0 is never blanked.
  always_comb begin
    fmt  = '0;
    nib  = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      if (nib != 4'd0) lead = 1'b0;
      if (ovf_q)
        fmt[8*i +: 8] = 8'h2D;
      else if (blank_q && lead && (i != 0))
        fmt[8*i +: 8] = 8'h20;
      else
        fmt[8*i +: 8] = {4'h3, nib};
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    chars_d = chars_q;
    oovf_d  = oovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          blank_d = blank_lz;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (64'(in_data) >= LIMIT);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == LAST) begin
          chars_d = fmt;
          oovf_d  = ovf_q;
          state_d = S_DONE;
        end else begin
          bcd_d   = bcd_shl;
          shift_d = shift_shl;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      chars_q <= {DIGITS{8'h20}};
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      chars_q <= chars_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

// File: tb/tb_bin_to_ascii_dec.sv
// Bench for bin_to_ascii_dec: default (7/2) and wide (16/5) instances
// against an arithmetic decimal model plus directed literal vectors.
module tb_bin_to_ascii_dec;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [6:0]  a_in_data = '0;
  logic        a_blank = 1'b0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [15:0] a_out_chars;
  logic        a_out_ovf;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_in_data = '0;
  logic        b_blank = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [39:0] b_out_chars;
  logic        b_out_ovf;

  bin_to_ascii_dec #(.IN_W(7), .DIGITS(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .blank_lz(a_blank),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_chars(a_out_chars), .out_ovf(a_out_ovf)
  );

  bin_to_ascii_dec #(.IN_W(16), .DIGITS(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .blank_lz(b_blank),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_chars(b_out_chars), .out_ovf(b_out_ovf)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [79:0] a_exp, a_shown, b_exp, b_shown;
  bit a_exp_ovf, a_shown_ovf, a_pend, a_prev_v;
  bit b_exp_ovf, b_shown_ovf, b_pend, b_prev_v;
  int a_acc, b_acc;

  task automatic chk(input string nm, input logic [79:0] got,
                     input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [79:0] model_chars(input longint unsigned v,
                                              input int nd, input bit bl);
    logic [79:0] r = '0;
    int dig[10];
    longint unsigned x = v;
    bit seen = 1'b0;
    if (v >= pow10(nd)) begin
      for (int i = 0; i < nd; i++) r[8*i +: 8] = 8'h2D;
      return r;
    end
    for (int i = 0; i < nd; i++) begin
      dig[i] = int'(x % 10);
      x = x / 10;
    end
    for (int i = nd - 1; i >= 0; i--) begin
      if (dig[i] != 0) seen = 1'b1;
      if (bl && !seen && i > 0) r[8*i +: 8] = 8'h20;
      else r[8*i +: 8] = 8'h30 + 8'(dig[i]);
    end
    return r;
  endfunction

  // Scoreboard: capture accepted values, retire on output handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pend = 1'b0;
      b_pend = 1'b0;
      a_shown = 80'h2020;
      b_shown = 80'h2020202020;
      a_shown_ovf = 1'b0;
      b_shown_ovf = 1'b0;
    end else begin
      cyc++;
      if (a_out_valid && a_out_ready) a_pend = 1'b0;
      if (b_out_valid && b_out_ready) b_pend = 1'b0;
      if (a_in_valid && a_in_ready) begin
        a_exp = model_chars(longint'(a_in_data), 2, a_blank);
        a_exp_ovf = (a_in_data >= 7'd100);
        a_acc = cyc;
        a_pend = 1'b1;
      end
      if (b_in_valid && b_in_ready) begin
        b_exp = model_chars(longint'(b_in_data), 5, b_blank);
        b_exp_ovf = 1'b0;
        b_acc = cyc;
        b_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_in_ready", a_in_ready, !a_pend);
      if (a_out_valid) begin
        chk("a_valid_pend", a_pend, 1);
        if (!a_prev_v) chk("a_latency", cyc - a_acc, 8);
        chk("a_chars", a_out_chars, a_exp);
        chk("a_ovf", a_out_ovf, a_exp_ovf);
        a_shown = a_exp;
        a_shown_ovf = a_exp_ovf;
      end else begin
        chk("a_held_chars", a_out_chars, a_shown);
        chk("a_held_ovf", a_out_ovf, a_shown_ovf);
      end
      a_prev_v = a_out_valid;
      chk("b_in_ready", b_in_ready, !b_pend);
      if (b_out_valid) begin
        chk("b_valid_pend", b_pend, 1);
        if (!b_prev_v) chk("b_latency", cyc - b_acc, 17);
        chk("b_chars", b_out_chars, b_exp);
        chk("b_ovf", b_out_ovf, b_exp_ovf);
        b_shown = b_exp;
        b_shown_ovf = b_exp_ovf;
      end else begin
        chk("b_held_chars", b_out_chars, b_shown);
        chk("b_held_ovf", b_out_ovf, b_shown_ovf);
      end
      b_prev_v = b_out_valid;
    end else begin
      a_prev_v = 1'b0;
      b_prev_v = 1'b0;
    end
  end

  task automatic a_send(input logic [6:0] v, input bit bl);
    int n = 0;
    while (!a_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) chk("a_send_timeout", a_in_ready, 1);
    a_in_valid = 1'b1;
    a_in_data = v;
    a_blank = bl;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data = '0;
  endtask

  task automatic a_wait();
    int n = 0;
    while (!a_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_out_valid) chk("a_done_timeout", a_out_valid, 1);
  endtask

  task automatic a_run(input string nm, input logic [6:0] v, input bit bl,
                       input logic [15:0] ec, input bit eo);
    a_send(v, bl);
    a_wait();
    chk(nm, a_out_chars, ec);
    chk({nm, "_ovf"}, a_out_ovf, eo);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic b_send(input logic [15:0] v, input bit bl);
    int n = 0;
    while (!b_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) chk("b_send_timeout", b_in_ready, 1);
    b_in_valid = 1'b1;
    b_in_data = v;
    b_blank = bl;
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_data = '0;
  endtask

  task automatic b_run(input string nm, input logic [15:0] v, input bit bl,
                       input logic [39:0] ec);
    int n = 0;
    b_send(v, bl);
    while (!b_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, b_out_valid, 1);
    chk(nm, b_out_chars, ec);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  // Random out_ready until the result is taken.
  task automatic b_drain();
    int n = 0;
    bit rel = 1'b0;
    while (!rel && n < 200) begin
      b_out_ready = 1'($urandom_range(0, 1));
      rel = b_out_valid && b_out_ready;
      @(negedge clk);
      n++;
    end
    b_out_ready = 1'b0;
    chk("b_drain_done", rel, 1);
  endtask

  initial begin
    int v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_a_ready", a_in_ready, 1);
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_chars", a_out_chars, 16'h2020);
    chk("rst_a_ovf", a_out_ovf, 0);
    chk("rst_b_chars", b_out_chars, 40'h2020202020);
    @(negedge clk);

    a_run("a7_blank", 7'd7, 1'b1, 16'h2037, 1'b0);
    a_run("a7_plain", 7'd7, 1'b0, 16'h3037, 1'b0);
    a_run("a0_blank", 7'd0, 1'b1, 16'h2030, 1'b0);
    a_run("a99", 7'd99, 1'b0, 16'h3939, 1'b0);
    a_run("a100", 7'd100, 1'b0, 16'h2D2D, 1'b1);
    a_run("a127", 7'd127, 1'b1, 16'h2D2D, 1'b1);

    a_send(7'd55, 1'b0);
    repeat (3) begin
      a_in_valid = 1'b1;
      a_in_data = 7'd3;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_wait();
    for (int k = 0; k < 5; k++) begin
      chk("a_bp_hold", a_out_chars, 16'h3535);
      chk("a_bp_ready", a_in_ready, 0);
      a_in_valid = k[0];
      a_in_data = 7'd9;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    a_run("a12_after_bp", 7'd12, 1'b0, 16'h3132, 1'b0);

    a_send(7'd88, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_a_ready", a_in_ready, 1);
    chk("mrst_a_valid", a_out_valid, 0);
    chk("mrst_a_chars", a_out_chars, 16'h2020);
    chk("mrst_a_ovf", a_out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    a_run("a42_after_rst", 7'd42, 1'b0, 16'h3432, 1'b0);

    b_run("b65535", 16'd65535, 1'b0, 40'h3635353335);
    b_run("b100_blank", 16'd100, 1'b1, 40'h2020313030);
    b_run("b0_plain", 16'd0, 1'b0, 40'h3030303030);
    b_run("b10000_blank", 16'd10000, 1'b1, 40'h3130303030);

    for (int i = 0; i < 1200; i++) begin
      if (i < 300) v = i;
      else if (i < 310) v = 65535 - (i - 300);
      else v = int'($urandom_range(0, 65535));
      b_send(16'(v), 1'($urandom_range(0, 1)));
      b_drain();
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
